// File: rtl/gcd_operand_feeder.sv
// gcd_operand_feeder
// Sequences one operand pair into the GCD unit and returns its answer.
// An operand pair is accepted on the in_* valid/ready port. The block pulses
// gcd_start, then drives A and B serially on gcd_data and waits for gcd_done.
// The result, or a timeout error, is returned on the res_* valid/ready port.
// A pair with a zero operand bypasses the GCD unit entirely.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    operand pair handshake, in_a/in_b operands
//   gcd_start            one-cycle start pulse to the GCD controlpath
//   gcd_data             shared data bus to the GCD datapath
//   gcd_done/gcd_result  completion level and result from the GCD unit
//   res_valid/res_ready  result handshake, res_data result, res_err timeout flag
module gcd_operand_feeder #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SEND_A,
        S_SEND_B,
        S_WAIT,
        S_OUT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [CNT_W-1:0] wait_cnt;

    // Sequencer: every output is registered and updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            reg_a     <= '0;
            reg_b     <= '0;
            wait_cnt  <= '0;
            in_ready  <= 1'b1;
            gcd_start <= 1'b0;
            gcd_data  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            gcd_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        reg_a    <= in_a;
                        reg_b    <= in_b;
                        in_ready <= 1'b0;
                        // gcd(0,x)=x and gcd(0,0)=0, so the OR is the answer.
                        if ((in_a == '0) || (in_b == '0)) begin
                            res_data  <= in_a | in_b;
                            res_err   <= 1'b0;
                            res_valid <= 1'b1;
                            state     <= S_OUT;
                        end else begin
                            gcd_start <= 1'b1;
                            gcd_data  <= '0;
                            state     <= S_START;
                        end
                    end
                end
                S_START: begin
                    gcd_data <= reg_a;
                    state    <= S_SEND_A;
                end
                S_SEND_A: begin
                    gcd_data <= reg_b;
                    state    <= S_SEND_B;
                end
                S_SEND_B: begin
                    gcd_data <= '0;
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // done wins over timeout when both land on the last cycle.
                    if (gcd_done) begin
                        res_data  <= gcd_result;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
                    end else if (wait_cnt == CNT_LAST) begin
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    gcd_data  <= '0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Testbench for gcd_operand_feeder: table-driven transactions against a small
// behavioural GCD unit model, plus hand-written stale-done and reset cases.
module tb_gcd_operand_feeder;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             gcd_start;
    logic [WIDTH-1:0] gcd_data;
    logic             gcd_done;
    logic [WIDTH-1:0] gcd_result;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;

    int checks   = 0;
    int failures = 0;

    // Model controls: done delay after B capture (-1 = never), stale-done mode.
    int model_delay = -1;
    bit stale_arm   = 1'b0;

    gcd_operand_feeder #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .gcd_start  (gcd_start),
        .gcd_data   (gcd_data),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int unsigned p = x;
        int unsigned q = y;
        int unsigned t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return WIDTH'(p);
    endfunction

    // Behavioural GCD unit: captures A and B after start, raises done later.
    int               m_phase;
    int               m_cnt;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase    <= 0;
            m_cnt      <= 0;
            m_a        <= '0;
            m_b        <= '0;
            gcd_done   <= 1'b0;
            gcd_result <= '0;
        end else if (gcd_start) begin
            m_phase <= 1;
            if (!stale_arm) gcd_done <= 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    if (stale_arm) begin
                        gcd_done   <= 1'b1;
                        gcd_result <= 16'd999;
                    end
                end
                1: begin
                    m_a     <= gcd_data;
                    m_phase <= 2;
                end
                2: begin
                    m_b <= gcd_data;
                    if (stale_arm) gcd_done <= 1'b0;
                    if (model_delay == 0) begin
                        gcd_done   <= 1'b1;
                        gcd_result <= ref_gcd(m_a, gcd_data);
                        m_phase    <= 0;
                    end else begin
                        m_cnt   <= 1;
                        m_phase <= 3;
                    end
                end
                3: begin
                    if (model_delay > 0 && m_cnt == model_delay) begin
                        gcd_done   <= 1'b1;
                        gcd_result <= ref_gcd(m_a, m_b);
                        m_phase    <= 0;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One transaction; ek = cycles from the accept edge to the first res_valid sample.
    task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int delay, input bit stale,
                           input logic [WIDTH-1:0] ed, input logic ee,
                           input int ek, input int hold);
        bit byp;
        bit seen;
        int k;
        int starts;
        byp = (a == '0) || (b == '0);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        model_delay = delay;
        stale_arm   = stale;
        in_a        = a;
        in_b        = b;
        in_valid    = 1'b1;
        res_ready   = 1'b0;
        tick();
        in_valid = 1'b0;
        in_a     = 16'hDEAD;
        in_b     = 16'hBEEF;
        seen     = 1'b0;
        starts   = 0;
        k        = 0;
        while (k <= 40) begin
            if (gcd_start) starts++;
            if (k == 0) begin
                check("in_ready_after_accept", 32'(in_ready), 32'd0);
                check("gcd_data_during_start", 32'(gcd_data), 32'd0);
            end
            if (k == 1 && !byp) check("gcd_data_a", 32'(gcd_data), 32'(a));
            if (k == 2 && !byp) check("gcd_data_b", 32'(gcd_data), 32'(b));
            if (k == 3 && !byp) check("gcd_data_wait", 32'(gcd_data), 32'd0);
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
            k++;
        end
        check("res_valid_seen", 32'(seen), 32'd1);
        check("latency", 32'(k), 32'(ek));
        check("start_pulses", 32'(starts), byp ? 32'd0 : 32'd1);
        check("res_data", 32'(res_data), 32'(ed));
        check("res_err", 32'(res_err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_res_data", 32'(res_data), 32'(ed));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        stale_arm = 1'b0;
        check("res_valid_after_handoff", 32'(res_valid), 32'd0);
        check("in_ready_after_handoff", 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               delay;
        logic [WIDTH-1:0] exp_data;
        logic             exp_err;
        int               exp_k;
        int               hold;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{a: 16'd143,   b: 16'd78,    delay: 6,  exp_data: 16'd13,    exp_err: 1'b0, exp_k: 10, hold: 0};
        vecs[1] = '{a: 16'd143,   b: 16'd78,    delay: 6,  exp_data: 16'd13,    exp_err: 1'b0, exp_k: 10, hold: 5};
        vecs[2] = '{a: 16'd0,     b: 16'd25,    delay: 6,  exp_data: 16'd25,    exp_err: 1'b0, exp_k: 0,  hold: 0};
        vecs[3] = '{a: 16'd0,     b: 16'd0,     delay: 6,  exp_data: 16'd0,     exp_err: 1'b0, exp_k: 0,  hold: 0};
        vecs[4] = '{a: 16'd40,    b: 16'd0,     delay: 6,  exp_data: 16'd40,    exp_err: 1'b0, exp_k: 0,  hold: 2};
        vecs[5] = '{a: 16'd12,    b: 16'd18,    delay: 0,  exp_data: 16'd6,     exp_err: 1'b0, exp_k: 4,  hold: 0};
        vecs[6] = '{a: 16'd17,    b: 16'd5,     delay: 2,  exp_data: 16'd1,     exp_err: 1'b0, exp_k: 6,  hold: 0};
        vecs[7] = '{a: 16'd100,   b: 16'd75,    delay: -1, exp_data: 16'd0,     exp_err: 1'b1, exp_k: 11, hold: 1};
        vecs[8] = '{a: 16'd21,    b: 16'd14,    delay: 7,  exp_data: 16'd7,     exp_err: 1'b0, exp_k: 11, hold: 0};
        vecs[9] = '{a: 16'd65535, b: 16'd65535, delay: 1,  exp_data: 16'd65535, exp_err: 1'b0, exp_k: 5,  hold: 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_gcd_start", 32'(gcd_start), 32'd0);
        check("reset_gcd_data", 32'(gcd_data), 32'd0);
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_res_data", 32'(res_data), 32'd0);
        check("reset_res_err", 32'(res_err), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        foreach (vecs[i])
            run_txn(vecs[i].a, vecs[i].b, vecs[i].delay, 1'b0,
                    vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_k, vecs[i].hold);

        // Stale done held through START/SEND must not be taken as the result.
        run_txn(16'd48, 16'd18, 3, 1'b1, 16'd6, 1'b0, 7, 0);

        // Done arriving on the timeout cycle's successor still yields an error.
        run_txn(16'd9, 16'd6, 8, 1'b0, 16'd0, 1'b1, 11, 0);

        // Asynchronous reset in the middle of WAIT.
        model_delay = -1;
        in_a        = 16'd100;
        in_b        = 16'd75;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("midwait_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_gcd_start", 32'(gcd_start), 32'd0);
        check("async_rst_gcd_data", 32'(gcd_data), 32'd0);
        check("async_rst_res_valid", 32'(res_valid), 32'd0);
        check("async_rst_res_data", 32'(res_data), 32'd0);
        check("async_rst_res_err", 32'(res_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        run_txn(16'd21, 16'd14, 2, 1'b0, 16'd7, 1'b0, 6, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gcd_operand_feeder.md
# gcd_operand_feeder

Sequencer that drives the operand side of the GCD datapath/controlpath pair and collects its answer. It accepts an operand pair on a valid/ready input port and issues the GCD start pulse. It then presents A and B serially on the shared 16-bit data bus, waits for done, and returns the result (or a timeout error) on a valid/ready output port. It sits between the system-side requester and the GCD unit, replacing hand-timed stimulus.

## Interface
- WIDTH, 16, operand/result width; matches GCD data bus.
- TIMEOUT, 255, max WAIT cycles before declaring error; ≥2.
- clk  in  1  rising-edge clock shared with GCD unit.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  feeder can accept pair.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- gcd_start  out  1  one-cycle start pulse to GCD controlpath.
- gcd_data  out  WIDTH  shared data_in bus to GCD datapath.
- gcd_done  in  1  GCD done level.
- gcd_result  in  WIDTH  GCD A-register output (valid when gcd_done=1).
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_data  out  WIDTH  GCD result.
- res_err  out  1  qualifies res_data: 1 = timeout, res_data=0.

## Operation
- States: IDLE, START, SEND_A, SEND_B, WAIT, OUT.
- IDLE: in_ready=1. On in_valid, register in_a/in_b.
  - Either operand zero: bypass. Go to OUT with res_data = in_a|in_b (gcd(0,x)=x, gcd(0,0)=0), res_err=0. GCD untouched.
  - Otherwise go to START.
- START: gcd_start=1, gcd_data=0 → SEND_A.
- SEND_A: gcd_data=A → SEND_B.
- SEND_B: gcd_data=B → WAIT; clear timeout counter.
- WAIT:
  - gcd_done=1: capture gcd_result into res_data, res_err=0 → OUT.
  - Otherwise increment counter. If counter reaches TIMEOUT-1 without done: res_data=0, res_err=1 → OUT.
- OUT: res_valid=1; res_data/res_err held stable. On res_ready → IDLE.
- gcd_done is ignored in every state except WAIT; a stale done from a prior operation during START/SEND is not a result.
- gcd_data=0 in all states other than SEND_A/SEND_B.
- Counter width $clog2(TIMEOUT+1); saturates, never wraps.

## Timing
- Reset (async, immediate): state=IDLE; in_ready=1; gcd_start=0; gcd_data=0; res_valid=0; res_data=0; res_err=0; counter=0.
- Reset mid-operation: all outputs return to reset values immediately. Any in-flight GCD operation is abandoned; the next START restarts the GCD.
- Accept at edge E0. gcd_start is high during cycle E0→E1, A during E1→E2, B during E2→E3, and WAIT begins at E3.
- gcd_done first sampled high at WAIT edge Ek → res_valid high from Ek, i.e. the cycle after done is seen.
- Minimum non-bypass latency, accept to res_valid: 4 cycles (done already high on first WAIT edge).
- Bypass latency: res_valid high 1 cycle after accept.
- Timeout: res_valid with res_err=1 exactly TIMEOUT cycles after WAIT entry if done never rises.
- res_valid&&res_ready at edge: returns to IDLE; in_ready=1 next cycle. No back-to-back accept in the same edge as result handoff.
- in_ready=0 in all states but IDLE; in_a/in_b are don't-care then.

## Test plan
- Normal: in_a=143, in_b=78; bench GCD model raises done 6 cycles after B with result 13. Expect gcd_start 1 cycle, gcd_data=143 then 78 on consecutive cycles; res_valid=1, res_data=13, res_err=0.
- Backpressure: same pair, res_ready held low 5 cycles. res_valid/res_data=13 stay stable; in_ready=0 until handoff.
- Zero bypass: (0,25) → res_data=25 one cycle after accept, gcd_start never asserted. (0,0) → res_data=0, res_err=0.
- Timeout (TIMEOUT=8): model never raises done. res_valid with res_err=1, res_data=0 exactly 8 cycles after WAIT entry.
- Stale done: model holds done=1 through START/SEND, drops it, then raises it with result 6 for (48,18). Expect res_data=6; the earlier done is not captured.
- Reset mid-WAIT: assert rst asynchronously. All outputs reset immediately, in_ready=1 after release; next pair (21,14) → res_data=7.
